// File: rtl/shift_reg_act_tile.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_act_tile
//  Description : Activation shift-window buffer. Packs a stream of DATA_W-bit
//                activations into a DEPTH-word window and presents it as a
//                flat tile with a valid/ready handshake. After the first full
//                window, only STRIDE new words are needed for the next
//                (overlapping) tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_act_tile #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 36,
    parameter int STRIDE = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W*DEPTH-1:0]      window,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_WIN_W = DATA_W * DEPTH;

    // Last count value before a tile completes, in the fill and slide phases.
    localparam logic [c_CNT_W-1:0] c_FILL_LAST  = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_SLIDE_LAST = c_CNT_W'(STRIDE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    // Reject illegal configurations at elaboration time.
    generate
        if (DEPTH < 2 || STRIDE < 1 || STRIDE > DEPTH) begin : g_bad_params
            $error("shift_reg_act_tile: need DEPTH >= 2 and 1 <= STRIDE <= DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,   // building the first window after reset/clear
        ST_FULL  = 2'd1,   // tile presented, waiting for the consumer
        ST_SLIDE = 2'd2    // collecting STRIDE words for the next overlapping tile
    } state_t;

    state_t                  r_state;
    logic [c_WIN_W-1:0]      r_window;
    logic [c_CNT_W-1:0]      r_fill_cnt;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_word_acc;
    logic                    w_tile_acc;
    logic [c_WIN_W-1:0]      w_window_shifted;

    // Input is only blocked while a tile is pending and not being taken now.
    assign w_in_ready       = !r_out_valid || out_ready;
    assign w_word_acc       = in_valid && w_in_ready;
    assign w_tile_acc       = r_out_valid && out_ready;
    assign w_window_shifted = {r_window[DATA_W*(DEPTH-1)-1:0], in_data};

    // Window, fill counter and tile-state sequencing with registered out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_window    <= '0;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            // Flush: any pending tile and any word offered this cycle are dropped.
            r_state     <= ST_FILL;
            r_window    <= '0;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_word_acc) begin
                r_window <= w_window_shifted;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_word_acc) begin
                        if (r_fill_cnt == c_FILL_LAST) begin
                            r_state     <= ST_FULL;
                            r_fill_cnt  <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_fill_cnt  <= r_fill_cnt + c_CNT_ONE;
                        end
                    end
                end

                ST_FULL: begin
                    // in_ready is low here unless the tile is being taken,
                    // so a word accept can only coincide with a tile accept.
                    if (w_tile_acc) begin
                        if (w_word_acc) begin
                            if (STRIDE == 1) begin
                                // The new word alone completes the next tile.
                                r_fill_cnt  <= '0;
                            end else begin
                                r_state     <= ST_SLIDE;
                                r_fill_cnt  <= c_CNT_ONE;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_state     <= ST_SLIDE;
                            r_fill_cnt  <= '0;
                            r_out_valid <= 1'b0;
                        end
                    end
                end

                ST_SLIDE: begin
                    if (w_word_acc) begin
                        if (r_fill_cnt == c_SLIDE_LAST) begin
                            r_state     <= ST_FULL;
                            r_fill_cnt  <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_fill_cnt  <= r_fill_cnt + c_CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_FILL;
                    r_fill_cnt  <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign window    = r_window;
    assign fill_cnt  = r_fill_cnt;

endmodule
`default_nettype wire
